spi_reg_master: RTL

- SPI initiator (master) that drives single-register read/write frames into the chip's SPI register-file slave (config/status register bank).
- Used in the on-chip self-test loopback path and in the companion FPGA/test harness.
- Accepts one command per valid/ready handshake, serialises it MSB-first, returns read data with a one-cycle response pulse.
- Supports all four SPI modes. SCLK is derived from the system clock by a programmable divider.

---
 rtl/spi_reg_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// SPI initiator for single-register read/write frames {rw, addr, data}, MSB first.
// It supports all four SPI modes, and SCLK runs at clk / (2*CLK_DIV).
module spi_reg_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [REG_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int FRAME_LEN = 1 + ADDR_WIDTH + REG_WIDTH;
  localparam int HP_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W     = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                 state_r;
  logic [HP_W-1:0]        hp_cnt_r;
  logic [BIT_W-1:0]       bit_cnt_r;
  logic                   phase_b_r;
  logic                   cpol_r;
  logic                   cpha_r;
  logic [FRAME_LEN-1:0]   tx_r;
  logic [REG_WIDTH-1:0]   rx_r;
  logic                   hp_last_s;

  // End of the current half-period.
  always_comb begin
    hp_last_s = (hp_cnt_r == HP_W'(CLK_DIV - 1));
  end

  // Frame sequencer: state, counters, shift registers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      hp_cnt_r  <= {HP_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      phase_b_r <= 1'b0;
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      tx_r      <= {FRAME_LEN{1'b0}};
      rx_r      <= {REG_WIDTH{1'b0}};
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= {REG_WIDTH{1'b0}};
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else if (ena) begin
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Track the requested idle level so SCLK is already correct when CS falls.
          spi_clk <= mode[1];
          if (cmd_valid && cmd_ready) begin
            tx_r      <= {cmd_write, cmd_addr, (cmd_write ? cmd_wdata : {REG_WIDTH{1'b0}})};
            cpol_r    <= mode[1];
            cpha_r    <= mode[0];
            spi_mosi  <= cmd_write;
            spi_cs_n  <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            hp_cnt_r  <= {HP_W{1'b0}};
            bit_cnt_r <= BIT_W'(FRAME_LEN - 1);
            phase_b_r <= 1'b0;
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (hp_last_s) begin
            hp_cnt_r  <= {HP_W{1'b0}};
            phase_b_r <= 1'b0;
            spi_mosi  <= tx_r[FRAME_LEN-1];
            spi_clk   <= cpha_r ? ~cpol_r : cpol_r;
            state_r   <= ST_SHIFT;
          end else begin
            hp_cnt_r <= hp_cnt_r + HP_W'(1);
          end
        end
        ST_SHIFT: begin
          if (hp_last_s) begin
            hp_cnt_r <= {HP_W{1'b0}};
            if (!phase_b_r) begin
              phase_b_r <= 1'b1;
              spi_clk   <= cpha_r ? cpol_r : ~cpol_r;
            end else begin
              // Late sample at the end of phase B; older bits fall off the top.
              rx_r      <= {rx_r[REG_WIDTH-2:0], spi_miso};
              phase_b_r <= 1'b0;
              if (bit_cnt_r == {BIT_W{1'b0}}) begin
                spi_clk <= cpol_r;
                state_r <= ST_HOLD;
              end else begin
                bit_cnt_r <= bit_cnt_r - BIT_W'(1);
                tx_r      <= {tx_r[FRAME_LEN-2:0], 1'b0};
                spi_mosi  <= tx_r[FRAME_LEN-2];
                spi_clk   <= cpha_r ? ~cpol_r : cpol_r;
              end
            end
          end else begin
            hp_cnt_r <= hp_cnt_r + HP_W'(1);
          end
        end
        ST_HOLD: begin
          if (hp_last_s) begin
            hp_cnt_r  <= {HP_W{1'b0}};
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_r;
            state_r   <= ST_GAP;
          end else begin
            hp_cnt_r <= hp_cnt_r + HP_W'(1);
          end
        end
        ST_GAP: begin
          if (hp_last_s) begin
            hp_cnt_r  <= {HP_W{1'b0}};
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            spi_clk   <= mode[1];
            state_r   <= ST_IDLE;
          end else begin
            hp_cnt_r <= hp_cnt_r + HP_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          hp_cnt_r  <= {HP_W{1'b0}};
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          spi_cs_n  <= 1'b1;
          spi_mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule
